// File: rtl/regfile_multiport_if.sv
// Register file access bundle: read ports, write port and bulk-clear handshake.
// master: decode/writeback side driving addresses, write data and clear requests.
// slave: the register file returning read data, write ack and clear status.
interface regfile_multiport_if #(
  parameter int WIDTH      = 64,
  parameter int AW         = 5,
  parameter int READ_PORTS = 2
);
  logic [READ_PORTS*AW-1:0]    rd_addr;
  logic [READ_PORTS*WIDTH-1:0] rd_data;
  logic                        wr_en;
  logic [AW-1:0]               wr_addr;
  logic [WIDTH-1:0]            wr_data;
  logic                        wr_ack;
  logic                        clr_req;
  logic                        clr_busy;
  logic                        clr_done;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, clr_req,
    input  rd_data, wr_ack, clr_busy, clr_done
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, clr_req,
    output rd_data, wr_ack, clr_busy, clr_done
  );
endinterface

// File: rtl/regfile_multiport.sv
// Multi-port register file: N combinational read ports with write bypass, one
// synchronous write port, a hardwired-zero register and a sequential bulk clear.
// Ports: clk, reset (async active-high), bus (regfile_multiport_if slave).
// Latency: reads 0 cycles; writes visible next cycle (same cycle via bypass).
// Backpressure: wr_ack drops while the clear engine runs; unacked writes are lost.
module regfile_multiport #(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 32,
  parameter int READ_PORTS = 2,
  parameter int ZERO_IDX   = 31
) (
  input logic                clk,
  input logic                reset,
  regfile_multiport_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [1:0]       r_state;
  logic [AW-1:0]    r_cnt;

  logic w_busy;
  logic w_wr_ack;
  logic [WIDTH-1:0]            w_rd [READ_PORTS];
  logic [READ_PORTS*WIDTH-1:0] w_rd_packed;

  // An address maps to real storage only if it is in range and not the zero register.
  function automatic logic addr_live(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) && (int'(a) != ZERO_IDX);
  endfunction

  assign w_busy   = (r_state == S_CLEAR);
  // Reset gates the ack so nothing looks accepted while state is being cleared.
  assign w_wr_ack = bus.wr_en & ~w_busy & ~reset;

  assign bus.wr_ack   = w_wr_ack;
  assign bus.clr_busy = w_busy;
  assign bus.clr_done = (r_state == S_DONE);

  // Clear sequencer: walks r_cnt through every entry, then pulses done once.
  // clr_req is only looked at in IDLE, so requests in CLEAR/DONE are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.clr_req) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
          end
        end
        S_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Storage. The clear wins the array while busy; the write path is acked off
  // in that state anyway. A write accepted on the clear-start edge lands here
  // and is wiped later when the sweep reaches its entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (r_state == S_CLEAR) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_ack && addr_live(bus.wr_addr)) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Read ports resolve independently. The zero/out-of-range test comes first so
  // a bypass to a dead address still reads 0; bypass is implicitly off in
  // CLEAR because w_wr_ack is low there.
  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [AW-1:0] w_addr;
    assign w_addr = bus.rd_addr[p*AW +: AW];
    assign w_rd[p] = !addr_live(w_addr)                  ? '0 :
                     (w_wr_ack && bus.wr_addr == w_addr) ? bus.wr_data :
                                                           r_mem[w_addr];
  end

  always_comb begin
    w_rd_packed = '0;
    for (int p = 0; p < READ_PORTS; p++) w_rd_packed[p*WIDTH +: WIDTH] = w_rd[p];
  end

  assign bus.rd_data = w_rd_packed;
endmodule

// File: tb/tb_regfile_multiport.sv
module tb_regfile_multiport;
  localparam int W  = 64;
  localparam int D  = 32;
  localparam int RP = 2;
  localparam int ZI = 31;
  localparam int AW = 5;

  localparam int D2  = 24;
  localparam int RP2 = 4;

  logic clk;
  logic reset;
  int   nchk = 0;
  int   nerr = 0;

  regfile_multiport_if #(.WIDTH(W), .AW(AW), .READ_PORTS(RP))  b1 ();
  regfile_multiport_if #(.WIDTH(W), .AW(AW), .READ_PORTS(RP2)) b2 ();

  regfile_multiport #(.WIDTH(W), .DEPTH(D), .READ_PORTS(RP), .ZERO_IDX(ZI)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  regfile_multiport #(.WIDTH(W), .DEPTH(D2), .READ_PORTS(RP2), .ZERO_IDX(D2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (b2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model for the 32-entry, 2-port instance --------
  // Contents as an array; the clear is tracked as "next index to wipe"
  // (-1 when no sweep is running) plus a flag for the completion cycle.
  logic [W-1:0] m_mem [D];
  int           m_clr_pos;
  bit           m_done;

  function automatic bit m_ack();
    return !reset && b1.wr_en && (m_clr_pos < 0);
  endfunction

  function automatic logic [W-1:0] m_rd(input logic [AW-1:0] a);
    if (reset) return '0;
    if (int'(a) == ZI || int'(a) >= D) return '0;
    if (m_ack() && b1.wr_addr == a) return b1.wr_data;
    return m_mem[a];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < D; i++) m_mem[i] = '0;
      m_clr_pos = -1;
      m_done    = 1'b0;
    end else begin
      if (m_ack() && int'(b1.wr_addr) != ZI && int'(b1.wr_addr) < D)
        m_mem[b1.wr_addr] = b1.wr_data;
      if (m_clr_pos >= 0) begin
        m_mem[m_clr_pos] = '0;
        m_clr_pos++;
        if (m_clr_pos == D) begin
          m_clr_pos = -1;
          m_done    = 1'b1;
        end
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (b1.clr_req) begin
        m_clr_pos = 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int p = 0; p < RP; p++)
      chk($sformatf("rd%0d", p), b1.rd_data[p*W +: W], m_rd(b1.rd_addr[p*AW +: AW]));
    chk("wr_ack",   {63'd0, b1.wr_ack},   {63'd0, m_ack()});
    chk("clr_busy", {63'd0, b1.clr_busy}, {63'd0, (!reset && m_clr_pos >= 0)});
    chk("clr_done", {63'd0, b1.clr_done}, {63'd0, (!reset && m_done)});
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill();
    for (int i = 0; i < 31; i++) begin
      b1.wr_en   = 1'b1;
      b1.wr_addr = AW'(i);
      b1.wr_data = W'(i + 1);
      step();
    end
    b1.wr_en = 1'b0;
  endtask

  int busy_n, done_n, done_at;
  logic [AW-1:0] a0, a1;

  initial begin
    reset      = 1'b1;
    b1.rd_addr = '0; b1.wr_en = 1'b0; b1.wr_addr = '0; b1.wr_data = '0; b1.clr_req = 1'b0;
    b2.rd_addr = '0; b2.wr_en = 1'b0; b2.wr_addr = '0; b2.wr_data = '0; b2.clr_req = 1'b0;
    step(); step();
    reset = 1'b0;
    step();

    // 1: every address reads 0 after reset on both ports
    for (int a = 0; a < D; a++) begin
      a0 = AW'(a);
      a1 = AW'(31 - a);
      b1.rd_addr = {a1, a0};
      @(negedge clk);
      chk("t1_rd", b1.rd_data[127:64] | b1.rd_data[63:0], 64'd0);
      step();
    end
    chk("t1_busy", {63'd0, b1.clr_busy}, 64'd0);

    // 2: write reg 5; port 1 bypasses in the write cycle, port 0 sees old 0
    b1.wr_en = 1'b1; b1.wr_addr = 5'd5; b1.wr_data = 64'hDEAD_BEEF_0000_0005;
    b1.rd_addr = {5'd5, 5'd0};
    @(negedge clk);
    chk("t2_bypass",  b1.rd_data[127:64], 64'hDEAD_BEEF_0000_0005);
    chk("t2_nobyp",   b1.rd_data[63:0],   64'd0);
    step();
    b1.wr_en = 1'b0; b1.rd_addr = {5'd0, 5'd5};
    @(negedge clk);
    chk("t2_stored",  b1.rd_data[63:0], 64'hDEAD_BEEF_0000_0005);
    step();

    // 3: zero register ignores writes, including via bypass
    b1.wr_en = 1'b1; b1.wr_addr = 5'd31; b1.wr_data = 64'hFFFF;
    b1.rd_addr = {5'd5, 5'd31};
    @(negedge clk);
    chk("t3_ack",    {63'd0, b1.wr_ack}, 64'd1);
    chk("t3_zbyp",   b1.rd_data[63:0], 64'd0);
    step();
    b1.wr_en = 1'b0;
    @(negedge clk);
    chk("t3_zread",  b1.rd_data[63:0], 64'd0);
    step();

    // 4: fill then bulk clear; clr_req held into CLEAR, writes attempted while busy
    fill();
    b1.rd_addr = {5'd30, 5'd2};
    @(negedge clk);
    chk("t4_pre2",  b1.rd_data[63:0],   64'd3);
    chk("t4_pre30", b1.rd_data[127:64], 64'd31);
    b1.clr_req = 1'b1;
    step();
    busy_n = 0; done_n = 0; done_at = -1;
    for (int c = 0; c < 40; c++) begin
      b1.clr_req = (c < 5);
      b1.wr_en   = (c >= 3 && c < 10);
      b1.wr_addr = 5'd2;
      b1.wr_data = 64'h77;
      @(negedge clk);
      if (b1.clr_busy) busy_n++;
      if (b1.clr_done) begin done_n++; done_at = c; end
      if (c == 4) chk("t4_ack_busy", {63'd0, b1.wr_ack}, 64'd0);
      step();
    end
    b1.clr_req = 1'b0; b1.wr_en = 1'b0;
    chk("t4_busy_cycles", 64'(busy_n), 64'd32);
    chk("t4_done_pulses", 64'(done_n), 64'd1);
    chk("t4_done_cycle",  64'(done_at), 64'd32);
    for (int a = 0; a < D; a += 2) begin
      a0 = AW'(a);
      a1 = AW'(a + 1);
      b1.rd_addr = {a1, a0};
      @(negedge clk);
      chk("t4_cleared", b1.rd_data[127:64] | b1.rd_data[63:0], 64'd0);
      step();
    end

    // 5: write on the clear-start edge, then reset 10 cycles into the clear
    fill();
    b1.clr_req = 1'b1; b1.wr_en = 1'b1; b1.wr_addr = 5'd20; b1.wr_data = 64'hAB;
    step();
    b1.clr_req = 1'b0; b1.wr_en = 1'b0; b1.rd_addr = {5'd0, 5'd20};
    @(negedge clk);
    chk("t5_wr_at_start", b1.rd_data[63:0],   64'hAB);
    chk("t5_reg0_before", b1.rd_data[127:64], 64'd1);
    chk("t5_busy",        {63'd0, b1.clr_busy}, 64'd1);
    for (int c = 0; c < 9; c++) step();
    #2;
    reset = 1'b1;
    #1;
    chk("t5_busy_async", {63'd0, b1.clr_busy}, 64'd0);
    done_n = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (b1.clr_done) done_n++;
    end
    step();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (b1.clr_done) done_n++;
    end
    chk("t5_no_done", 64'(done_n), 64'd0);
    step();
    for (int a = 0; a < 31; a += 2) begin
      a0 = AW'(a);
      a1 = AW'(a + 1);
      b1.rd_addr = {a1, a0};
      @(negedge clk);
      chk("t5_regs_zero", b1.rd_data[127:64] | b1.rd_data[63:0], 64'd0);
      step();
    end

    // 6: 24-entry, 4-port instance: out-of-range and broadcast reads
    b2.wr_en = 1'b1; b2.wr_addr = 5'd3; b2.wr_data = 64'h1234_5678_9ABC_DEF0;
    step();
    b2.wr_en = 1'b1; b2.wr_addr = 5'd27; b2.wr_data = 64'hBAD;
    b2.rd_addr = {5'd3, 5'd3, 5'd3, 5'd3};
    @(negedge clk);
    chk("t6_ack27", {63'd0, b2.wr_ack}, 64'd1);
    for (int p = 0; p < RP2; p++)
      chk($sformatf("t6_bcast%0d", p), b2.rd_data[p*W +: W], 64'h1234_5678_9ABC_DEF0);
    step();
    b2.wr_en = 1'b1; b2.wr_addr = 5'd27; b2.wr_data = 64'hBAD;
    b2.rd_addr = {5'd11, 5'd3, 5'd23, 5'd27};
    @(negedge clk);
    chk("t6_oor_byp", b2.rd_data[63:0],    64'd0);
    chk("t6_reg23",   b2.rd_data[127:64],  64'd0);
    chk("t6_reg3",    b2.rd_data[191:128], 64'h1234_5678_9ABC_DEF0);
    chk("t6_reg11",   b2.rd_data[255:192], 64'd0);
    step();
    b2.wr_en = 1'b0;
    @(negedge clk);
    chk("t6_oor_rd",  b2.rd_data[63:0],    64'd0);
    chk("t6_reg11b",  b2.rd_data[255:192], 64'd0);
    step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
